shift_req_queue: RTL and testbench
==================================

# shift_req_queue

Buffered request front-end for the combinational 32-bit left/right barrel shifter. Accepts shift commands (direction, amount, operand) on a valid/ready input port and queues them in a small FIFO. Issues the head entry to the shifter's `control`/`shift`/`num` inputs, and registers the shifter's `out` into a valid/ready result port. This decouples the producer (ALU issue logic) from the downstream consumer and sustains one shift per cycle.

## Interface

**Parameters**
- `DEPTH`, default 4: FIFO entries; power of 2, ≥ 2.
- `WIDTH`, default 32: operand/result width; must match the shifter.
- `SHW`, default 5: shift-amount width, equal to log2(WIDTH).

**Ports**
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: request present.
- `in_ready` output 1: queue can accept; equals `count != DEPTH`.
- `in_control` input 1: 0 = logical left, 1 = logical right.
- `in_shift` input SHW: shift amount.
- `in_num` input WIDTH: operand.
- `sh_control` output 1: to shifter `control`.
- `sh_shift` output SHW: to shifter `shift`.
- `sh_num` output WIDTH: to shifter `num`.
- `sh_out` input WIDTH: from shifter `out`; purely combinational from the `sh_*` outputs.
- `out_valid` output 1: result held in the output register.
- `out_ready` input 1: consumer accepts the result.
- `out_data` output WIDTH: registered shift result.
- `count` output log2(DEPTH)+1: current FIFO occupancy.

## Operation

- **Push:** `in_valid && in_ready` writes `{in_control, in_shift, in_num}` at `wr_ptr`, then `wr_ptr++`.
- **Full:** `in_ready` is low whenever `count == DEPTH`, even if a pop occurs in the same cycle. There is no push-through-full.
- **Issue:** `sh_*` outputs show the head entry (`rd_ptr`) combinationally. When the queue is empty, `sh_*` is all-zero (bypass case excepted; see Configuration).
- **Capture:** `cap = (count != 0) && (!out_valid || out_ready)`.
  - On `cap`: `out_data <= sh_out`, `out_valid <= 1`, `rd_ptr++`.
  - If `out_valid && out_ready && !cap`: `out_valid <= 0`, and `out_data` holds its last value.
- **Occupancy:** `count` updates +1 on push only, −1 on pop only, unchanged on simultaneous push and pop. Pointers wrap modulo DEPTH.
- **Ordering:** results leave strictly in request order. No request is dropped or duplicated.
- **Backpressure:** `out_valid` high with `out_ready` low holds `out_data` stable and stalls pops. The queue fills to DEPTH, then `in_ready` drops.
- **Arithmetic:** none in this block. The shift semantics belong to the shifter: shift 0 passes the operand; bits shifted out are lost; vacated bits are filled with 0.

## Timing

- **Reset values:** `in_ready=1`, `out_valid=0`, `out_data=0`, `count=0`, `sh_control=0`, `sh_shift=0`, `sh_num=0`. Pointers are 0.
- **Reset mid-operation:** all queued entries and any pending result are discarded. `out_valid` is 0 on the cycle after the reset edge.
- **Latency without bypass:** a request accepted at edge N becomes head in cycle N+1. It is captured at edge N+1, so `out_valid` is high from N+1. That is 2 edges, request to result.
- **Throughput:** with `out_ready` held high, one result per cycle.
- **Combinational path:** the path `rd_ptr → sh_* → shifter → sh_out → out_data` must close in one cycle. `in_ready` depends only on registered `count`.

## Configuration

- **Macro:** `SHIFT_QUEUE_BYPASS_EN`.
- **Defined:** when `count == 0`, `in_valid` is high, and the output register is free (`!out_valid || out_ready`):
  - `sh_*` carry the `in_*` fields directly.
  - `sh_out` is captured at the accepting edge, so `out_valid` is high one edge after acceptance.
  - The FIFO is not written, and `count` stays 0.
  - In all other cases, behaviour is the same as without the macro.
- **Undefined:** every request passes through the FIFO, with the fixed 2-edge latency.

## Test plan

- **Basic shifts:** bench instantiates `shift_req_queue` plus the shifter. Send `(0,3,31)`, `(1,3,31)`, `(0,31,127)`, `(1,31,127)` back-to-back with `out_ready=1` → `out_data` sequence 248, 3, 0x80000000, 0, on consecutive cycles, in order.
- **Edge operands:** send `(0,0,127)`, `(0,12,0)`, `(0,10,26)`, `(1,10,26)` → 127, 0, 26624, 0.
- **Backpressure:**
  - Hold `out_ready=0` and push 5 requests. First result appears; `count` reaches 4; `in_ready` drops.
  - Release `out_ready` → all 5 results drain in order; `in_ready` rises after the first pop.
- **Simultaneous push/pop:** at `count=2` with `out_ready=1`, push every cycle → `count` stays 2; results keep streaming.
- **Reset mid-stream:** assert `rst` for 1 cycle with 3 entries queued and `out_valid=1` → next cycle `out_valid=0`, `count=0`, `in_ready=1`, `out_data=0`. A following request `(0,1,1)` returns 2.
- **Bypass latency:** single `(0,4,1)` into an empty queue → `out_valid` high 1 edge after acceptance (result 16) with `SHIFT_QUEUE_BYPASS_EN`; 2 edges without it.

Source files
------------

// File: rtl/shift_req_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_req_queue_if
// Description : Bundles the request, shifter-issue and result ports of the
//               shift request queue. 'slave' is the queue's view; 'master'
//               is the view of the surrounding logic that produces requests,
//               supplies the combinational shifter result and consumes
//               results.
// Revision    : 1.0 - initial release
// ============================================================================
interface shift_req_queue_if #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    localparam int c_CW = $clog2(DEPTH) + 1;

    // Request port
    logic             in_valid;
    logic             in_ready;
    logic             in_control;
    logic [SHW-1:0]   in_shift;
    logic [WIDTH-1:0] in_num;

    // Shifter issue / return
    logic             sh_control;
    logic [SHW-1:0]   sh_shift;
    logic [WIDTH-1:0] sh_num;
    logic [WIDTH-1:0] sh_out;

    // Result port
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    // Occupancy
    logic [c_CW-1:0]  count;

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_control,
        input  in_shift,
        input  in_num,
        output sh_control,
        output sh_shift,
        output sh_num,
        input  sh_out,
        output out_valid,
        input  out_ready,
        output out_data,
        output count
    );

    modport master (
        output in_valid,
        input  in_ready,
        output in_control,
        output in_shift,
        output in_num,
        input  sh_control,
        input  sh_shift,
        input  sh_num,
        output sh_out,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  count
    );
endinterface
`default_nettype wire

// File: rtl/shift_req_queue.sv
`default_nettype none
// ============================================================================
// Module      : shift_req_queue
// Description : Buffered request front-end for a combinational barrel
//               shifter. Requests are queued in a DEPTH-entry FIFO, the head
//               entry drives the shifter, and the shifter result is captured
//               into a valid/ready output register (one result per cycle).
//               Optional feature macro: SHIFT_QUEUE_BYPASS_EN - when the
//               FIFO is empty and the output register is free, an incoming
//               request goes straight to the shifter and is captured on the
//               accepting edge without being written to the FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_req_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic              clk,
    input  logic              rst,
    shift_req_queue_if.slave  bus
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_EW = 1 + SHW + WIDTH;

    localparam logic [c_CW-1:0] c_FULL    = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);

    // Storage and pointers
    logic [c_EW-1:0]  r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;

    // Output register
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;

    // Handshake decode
    logic             w_in_ready;
    logic             w_out_free;
    logic             w_not_empty;
    logic             w_bypass;
    logic             w_push;
    logic             w_pop;
    logic             w_cap;

    // Entry views
    logic [c_EW-1:0]  w_in_entry;
    logic [c_EW-1:0]  w_head;

    // Shifter drive
    logic             w_sh_control;
    logic [SHW-1:0]   w_sh_shift;
    logic [WIDTH-1:0] w_sh_num;

    // ------------------------------------------------------------------
    // Handshake decode. in_ready looks only at the registered count, so a
    // full queue refuses a request even when a pop happens the same cycle.
    // ------------------------------------------------------------------
    assign w_in_ready  = (r_count != c_FULL);
    assign w_out_free  = !r_out_valid || bus.out_ready;
    assign w_not_empty = (r_count != '0);

`ifdef SHIFT_QUEUE_BYPASS_EN
    // Empty queue with a free output register: feed the request straight
    // into the shifter and capture it on the accepting edge.
    assign w_bypass = !w_not_empty && bus.in_valid && w_out_free;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed request never occupies a FIFO slot.
    assign w_push = bus.in_valid && w_in_ready && !w_bypass;
    // A pop is the capture of the head entry into the output register.
    assign w_pop  = w_not_empty && w_out_free;
    assign w_cap  = w_pop || w_bypass;

    assign w_in_entry = {bus.in_control, bus.in_shift, bus.in_num};
    assign w_head     = r_mem[r_rd_ptr];

    // ------------------------------------------------------------------
    // Select what the shifter sees: head entry, bypassed request, or zero.
    // ------------------------------------------------------------------
    always_comb begin
        w_sh_control = 1'b0;
        w_sh_shift   = '0;
        w_sh_num     = '0;
        if (w_not_empty) begin
            w_sh_control = w_head[c_EW-1];
            w_sh_shift   = w_head[WIDTH +: SHW];
            w_sh_num     = w_head[WIDTH-1:0];
        end else if (w_bypass) begin
            w_sh_control = bus.in_control;
            w_sh_shift   = bus.in_shift;
            w_sh_num     = bus.in_num;
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage: write the request at the write pointer on a push.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_entry;
        end
    end

    // ------------------------------------------------------------------
    // Pointers advance on push/pop and wrap naturally (DEPTH is 2^n).
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Occupancy: +1 on push only, -1 on pop only, held on both or neither.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Result register: load the shifter output on capture; drop valid when
    // the consumer takes the result and nothing replaces it. Data is held.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_cap) begin
            r_out_valid <= 1'b1;
            r_out_data  <= bus.sh_out;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Port drive
    assign bus.in_ready   = w_in_ready;
    assign bus.sh_control = w_sh_control;
    assign bus.sh_shift   = w_sh_shift;
    assign bus.sh_num     = w_sh_num;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_shift_req_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_req_queue
// Description : Self-checking bench for shift_req_queue. Models the external
//               combinational shifter, keeps a queue of expected results in
//               request order, and runs directed vectors plus random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_req_queue;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;
    localparam int SHW   = 5;
    localparam int NVEC  = 8;

`ifdef SHIFT_QUEUE_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic last_acc;

    logic [WIDTH-1:0] model_q [$];

    typedef struct {
        logic             c;
        logic [SHW-1:0]   s;
        logic [WIDTH-1:0] n;
        logic [WIDTH-1:0] exp;
    } vec_t;

    vec_t vecs [NVEC];

    shift_req_queue_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SHW(SHW)) bus ();

    shift_req_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // External barrel shifter: logical shifts, zero fill.
    assign bus.sh_out = bus.sh_control ? (bus.sh_num >> bus.sh_shift)
                                       : (bus.sh_num << bus.sh_shift);

    function automatic logic [WIDTH-1:0] ref_shift(logic c, logic [SHW-1:0] s,
                                                   logic [WIDTH-1:0] n);
        logic [WIDTH-1:0] r;
        r = n;
        for (int k = 0; k < int'(s); k++) begin
            r = c ? {1'b0, r[WIDTH-1:1]} : {r[WIDTH-2:0], 1'b0};
        end
        return r;
    endfunction

    task automatic checkw(string name, logic [WIDTH-1:0] act, logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic check1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b", name, act, exp);
        end
    endtask

    // One clock: sample handshakes before the edge, update the model after.
    task automatic tick();
        logic             acc;
        logic             del;
        logic             in_rst;
        logic [WIDTH-1:0] ddata;
        logic [WIDTH-1:0] aval;
        logic [WIDTH-1:0] expd;
        in_rst = rst;
        acc    = bus.in_valid && bus.in_ready;
        del    = bus.out_valid && bus.out_ready;
        ddata  = bus.out_data;
        aval   = ref_shift(bus.in_control, bus.in_shift, bus.in_num);
        @(posedge clk);
        #1;
        last_acc = acc && !in_rst;
        if (in_rst) begin
            model_q.delete();
        end else begin
            if (del) begin
                if (model_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_extra actual=0x%0h required=none", ddata);
                end else begin
                    expd = model_q.pop_front();
                    checkw("scoreboard_order", ddata, expd);
                end
            end
            if (acc) model_q.push_back(aval);
        end
    endtask

    task automatic send(logic c, logic [SHW-1:0] s, logic [WIDTH-1:0] n);
        bus.in_valid   = 1'b1;
        bus.in_control = c;
        bus.in_shift   = s;
        bus.in_num     = n;
        last_acc       = 1'b0;
        for (int k = 0; k < 40 && !last_acc; k++) tick();
        if (!last_acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=not_accepted required=accepted");
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 40 && (model_q.size() != 0 || bus.out_valid); k++) tick();
        check1("drain_complete", (model_q.size() == 0) && !bus.out_valid, 1'b1);
    endtask

    initial begin
        vecs[0] = '{1'b0, 5'd3,  32'd31,  32'd248};
        vecs[1] = '{1'b1, 5'd3,  32'd31,  32'd3};
        vecs[2] = '{1'b0, 5'd31, 32'd127, 32'h8000_0000};
        vecs[3] = '{1'b1, 5'd31, 32'd127, 32'd0};
        vecs[4] = '{1'b0, 5'd0,  32'd127, 32'd127};
        vecs[5] = '{1'b0, 5'd12, 32'd0,   32'd0};
        vecs[6] = '{1'b0, 5'd10, 32'd26,  32'd26624};
        vecs[7] = '{1'b1, 5'd10, 32'd26,  32'd0};

        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_control = 1'b0;
        bus.in_shift   = '0;
        bus.in_num     = '0;
        bus.out_ready  = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check1("reset_in_ready",   bus.in_ready,   1'b1);
        check1("reset_out_valid",  bus.out_valid,  1'b0);
        checkw("reset_out_data",   bus.out_data,   32'd0);
        checkw("reset_count",      WIDTH'(bus.count), 32'd0);
        check1("reset_sh_control", bus.sh_control, 1'b0);
        checkw("reset_sh_shift",   WIDTH'(bus.sh_shift), 32'd0);
        checkw("reset_sh_num",     bus.sh_num,     32'd0);

        // Table vectors back-to-back, one result per cycle in order
        bus.out_ready = 1'b1;
        for (int j = 0; j < NVEC + LAT; j++) begin
            int idx;
            if (j < NVEC) begin
                bus.in_valid   = 1'b1;
                bus.in_control = vecs[j].c;
                bus.in_shift   = vecs[j].s;
                bus.in_num     = vecs[j].n;
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
            idx = j + 1 - LAT;
            if (idx >= 0 && idx < NVEC) begin
                check1("vec_out_valid", bus.out_valid, 1'b1);
                checkw("vec_out_data", bus.out_data, vecs[idx].exp);
            end
        end
        drain();

        // Backpressure: 5 requests with the consumer stalled
        bus.out_ready = 1'b0;
        send(1'b0, 5'd1, 32'd5);
        send(1'b1, 5'd2, 32'd64);
        send(1'b0, 5'd8, 32'h0000_00ff);
        send(1'b1, 5'd4, 32'hf000_0000);
        send(1'b0, 5'd0, 32'h1234_5678);
        checkw("bp_count_full", WIDTH'(bus.count), 32'd4);
        check1("bp_in_ready_low", bus.in_ready, 1'b0);
        check1("bp_out_valid", bus.out_valid, 1'b1);
        checkw("bp_first_result", bus.out_data, 32'd10);
        bus.in_valid   = 1'b1;
        bus.in_control = 1'b0;
        bus.in_shift   = 5'd1;
        bus.in_num     = 32'd99;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkw("bp_hold_data", bus.out_data, 32'd10);
            checkw("bp_hold_count", WIDTH'(bus.count), 32'd4);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check1("bp_in_ready_rises", bus.in_ready, 1'b1);
        checkw("bp_count_after_pop", WIDTH'(bus.count), 32'd3);
        checkw("bp_second_result", bus.out_data, 32'd16);
        drain();

        // Simultaneous push and pop at count 2
        bus.out_ready = 1'b0;
        send(1'b0, 5'd2, 32'd1);
        send(1'b0, 5'd3, 32'd1);
        send(1'b0, 5'd4, 32'd1);
        checkw("pp_count_start", WIDTH'(bus.count), 32'd2);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.in_valid   = 1'b1;
            bus.in_control = k[0];
            bus.in_shift   = 5'(k + 1);
            bus.in_num     = 32'h0001_0000 + 32'(k);
            tick();
            checkw("pp_count_steady", WIDTH'(bus.count), 32'd2);
            check1("pp_streaming", bus.out_valid, 1'b1);
        end
        drain();

        // Reset with entries queued and a pending result
        bus.out_ready = 1'b0;
        send(1'b0, 5'd1, 32'd3);
        send(1'b0, 5'd2, 32'd3);
        send(1'b1, 5'd1, 32'd8);
        send(1'b1, 5'd2, 32'd8);
        checkw("mid_count_before", WIDTH'(bus.count), 32'd3);
        check1("mid_valid_before", bus.out_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check1("mid_rst_out_valid", bus.out_valid, 1'b0);
        checkw("mid_rst_count", WIDTH'(bus.count), 32'd0);
        check1("mid_rst_in_ready", bus.in_ready, 1'b1);
        checkw("mid_rst_out_data", bus.out_data, 32'd0);
        bus.out_ready = 1'b1;
        send(1'b0, 5'd1, 32'd1);
        repeat (LAT - 1) tick();
        check1("post_rst_valid", bus.out_valid, 1'b1);
        checkw("post_rst_result", bus.out_data, 32'd2);
        drain();

        // Latency of a single request into an empty queue
        bus.out_ready = 1'b1;
        send(1'b0, 5'd4, 32'd1);
        check1("lat_valid_after_accept", bus.out_valid, (LAT == 1) ? 1'b1 : 1'b0);
        repeat (LAT - 1) tick();
        check1("lat_valid", bus.out_valid, 1'b1);
        checkw("lat_result", bus.out_data, 32'd16);
        drain();

        // Random traffic against the scoreboard
        for (int k = 0; k < 400; k++) begin
            bus.in_valid   = ($urandom % 10) < 6;
            bus.in_control = 1'($urandom % 2);
            bus.in_shift   = 5'($urandom_range(0, 31));
            bus.in_num     = WIDTH'($urandom);
            bus.out_ready  = ($urandom % 10) < 6;
            tick();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
